// File: rtl/board_draw_ctrl.sv
// Frame sequencer for the 8x8 reversi board renderer: walks every cell, fetches its state
// from sync board RAM and plots a CELL x CELL square (with optional cursor border) to the VGA adapter.
module board_draw_ctrl #(
  parameter int         CELL_LOG2     = 2,
  parameter logic [7:0] X_OFFSET      = 8'd0,
  parameter logic [6:0] Y_OFFSET      = 7'd0,
  parameter logic [2:0] BG_COLOUR     = 3'b010,
  parameter logic [2:0] CURSOR_COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  input  logic       cursor_en,
  output logic [5:0] cell_addr,
  input  logic [1:0] cell_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);
  localparam int            PW   = CELL_LOG2;
  localparam logic [PW-1:0] PMAX = {PW{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [5:0]    cell_q, cell_d;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [5:0]    cur_q, cur_d;
  logic          cur_en_q, cur_en_d;
  logic [2:0]    piece_q, piece_d;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [2:0]    col_q, col_d;
  logic          plot_q, plot_d;

  logic          load;
  logic [PW-1:0] ld_px, ld_py;
  logic [2:0]    ld_piece;
  logic          ld_border, cur_hit;

  function automatic logic [2:0] map_colour(input logic [1:0] d);
    case (d)
      2'b11:   return 3'b000;
      2'b10:   return 3'b111;
      default: return BG_COLOUR;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    px_d     = px_q;
    py_d     = py_q;
    cur_d    = cur_q;
    cur_en_d = cur_en_q;
    piece_d  = piece_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    load     = 1'b0;
    ld_px    = '0;
    ld_py    = '0;
    ld_piece = piece_q;

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_FETCH;
        cell_d   = '0;
        cur_d    = {cursor_y, cursor_x};
        cur_en_d = cursor_en;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        // RAM data is only valid here; pixel 0 goes out on this same edge
        piece_d  = map_colour(cell_data);
        ld_piece = piece_d;
        px_d     = '0;
        py_d     = '0;
        load     = 1'b1;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        if (px_q == PMAX && py_q == PMAX) begin
          cell_d  = cell_q + 6'd1;
          state_d = (cell_q == 6'd63) ? S_DONE : S_FETCH;
        end else begin
          px_d = px_q + PW'(1);
          if (px_q == PMAX) py_d = py_q + PW'(1);
          load  = 1'b1;
          ld_px = px_d;
          ld_py = py_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cur_hit   = cur_en_q && (cell_q == cur_q);
    ld_border = (ld_px == '0) || (ld_px == PMAX) || (ld_py == '0) || (ld_py == PMAX);
    if (load) begin
      x_d    = X_OFFSET + (8'(cell_q[2:0]) << PW) + 8'(ld_px);
      y_d    = Y_OFFSET + (7'(cell_q[5:3]) << PW) + 7'(ld_py);
      col_d  = (cur_hit && ld_border) ? CURSOR_COLOUR : ld_piece;
      plot_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cell_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      cur_q    <= '0;
      cur_en_q <= 1'b0;
      piece_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      px_q     <= px_d;
      py_q     <= py_d;
      cur_q    <= cur_d;
      cur_en_q <= cur_en_d;
      piece_q  <= piece_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
    end
  end

  assign cell_addr  = cell_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = col_q;
  assign plot       = plot_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_DRAW);
  assign done       = (state_q == S_DONE);

endmodule
